gmii_tx_arb: RTL

GMII_TX_ARB -- requirements
Module: gmii_tx_arb

---
 rtl/gmii_arb_pkg.sv | 17 +
 rtl/rr_arb2.sv | 31 +++
 rtl/gmii_tx_arb.sv | 128 ++++++++++++
 3 files changed

// File: rtl/gmii_arb_pkg.sv
// rtl/gmii_arb_pkg.sv - shared FSM encoding and GMII framing constants for the TX arbiter
package gmii_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_DATA = 2'd2,
        ST_IFG  = 2'd3
    } arb_state_t;

    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE      = 8'hD5;

    // Shared phase counter width; PRE_BYTES and IFG_BYTES must fit.
    localparam int CNT_W = 8;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin selector with a last-granted pointer
module rr_arb2 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant
);

    // 1 means source 1 was granted last, so source 0 wins the next tie.
    logic last;

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last <= 1'b1;
        end else if (update && (|grant)) begin
            last <= grant[1];
        end
    end

endmodule

// File: rtl/gmii_tx_arb.sv
// rtl/gmii_tx_arb.sv - arbitrates two frame sources onto one GMII TX port with preamble, SFD and IFG
module gmii_tx_arb
    import gmii_arb_pkg::*;
#(
    parameter int IFG_BYTES = 12,
    parameter int PRE_BYTES = 7
) (
    input  logic        sys_clk,
    input  logic        reset_n,
    input  logic        req0,
    input  logic        req1,
    output logic        gnt0,
    output logic        gnt1,
    input  logic [7:0]  data0,
    input  logic [7:0]  data1,
    input  logic        valid0,
    input  logic        valid1,
    input  logic        last0,
    input  logic        last1,
    output logic        ready0,
    output logic        ready1,
    output logic [7:0]  gmii_txd,
    output logic        gmii_tx_en,
    output logic        gmii_tx_er,
    output logic        busy,
    output logic [15:0] underrun_cnt
);

    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PRE_BYTES);
    // The IDLE decision cycle and the first IFG cycle (still showing the last
    // byte) bracket the gap, so IFG itself lasts IFG_BYTES-1 cycles.
    localparam logic [CNT_W-1:0] IFG_LAST = CNT_W'(IFG_BYTES - 2);

    arb_state_t       state;
    arb_state_t       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             owner;
    logic [1:0]       arb_grant;
    logic             arb_update;
    logic             in_frame;
    logic             sel_valid;
    logic             sel_last;
    logic [7:0]       sel_data;

    assign arb_update = (state == ST_IDLE) && (req0 || req1);
    assign sel_valid  = owner ? valid1 : valid0;
    assign sel_last   = owner ? last1  : last0;
    assign sel_data   = owner ? data1  : data0;

    rr_arb2 u_rr_arb2 (
        .clk     (sys_clk),
        .reset_n (reset_n),
        .req     ({req1, req0}),
        .update  (arb_update),
        .grant   (arb_grant)
    );

    always_ff @(posedge sys_clk) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            owner <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= (state_nxt != state) ? '0 : cnt + 1'b1;
            if (arb_update) begin
                owner <= arb_grant[1];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (req0 || req1)       state_nxt = ST_PRE;
            ST_PRE:  if (cnt == PRE_LAST)    state_nxt = ST_DATA;
            ST_DATA: if (!sel_valid || sel_last) state_nxt = ST_IFG;
            ST_IFG:  if (cnt == IFG_LAST)    state_nxt = ST_IDLE;
            default:                         state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        in_frame = (state == ST_PRE) || (state == ST_DATA);
        gnt0     = in_frame && !owner;
        gnt1     = in_frame && owner;
        ready0   = gnt0 && (state == ST_DATA);
        ready1   = gnt1 && (state == ST_DATA);
        busy     = (state != ST_IDLE);
    end

    always_ff @(posedge sys_clk) begin
        if (!reset_n) begin
            gmii_txd     <= 8'h00;
            gmii_tx_en   <= 1'b0;
            gmii_tx_er   <= 1'b0;
            underrun_cnt <= 16'h0000;
        end else begin
            case (state)
                ST_PRE: begin
                    gmii_txd   <= (cnt == PRE_LAST) ? SFD_BYTE : PREAMBLE_BYTE;
                    gmii_tx_en <= 1'b1;
                    gmii_tx_er <= 1'b0;
                end
                ST_DATA: begin
                    gmii_tx_en <= 1'b1;
                    if (sel_valid) begin
                        gmii_txd   <= sel_data;
                        gmii_tx_er <= 1'b0;
                    end else begin
                        // Source starved mid-frame: poison the frame on the wire.
                        gmii_txd   <= 8'h00;
                        gmii_tx_er <= 1'b1;
                        if (underrun_cnt != 16'hFFFF) begin
                            underrun_cnt <= underrun_cnt + 16'h0001;
                        end
                    end
                end
                default: begin
                    gmii_txd   <= 8'h00;
                    gmii_tx_en <= 1'b0;
                    gmii_tx_er <= 1'b0;
                end
            endcase
        end
    end

endmodule
